instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  IF stage. Owns the program counter, fetches from instruction memory over a req/ready
//  handshake, and drives PC, instruction and PC_next into the IF/ID pipeline register.
//  Honours the hazard-unit stall (PC_WriteEN) and the EX-stage branch/jump redirect.
//  Inserts NOP bubbles while no valid instruction is available.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  NOP_INSTR  32'h0000_0013  instruction driven when fetch_valid=0 (addi x0,x0,0)
// PORTS
//  clk              in   1   clock, rising edge
//  rst              in   1   asynchronous reset, active-low
//  PC_WriteEN       in   1   1 = advance PC / accept instruction; 0 = stall (hazard unit)
//  redirect         in   1   branch taken or jump, from EX
//  redirect_target  in   32  new PC; bits [1:0] are forced to 0
//  imem_req         out  1   fetch request to instruction memory
//  imem_addr        out  32  fetch address; stable while imem_req=1 and imem_ready=0
//  imem_rdata       in   32  fetched word; valid when imem_ready=1
//  imem_ready       in   1   completes the request in the same cycle; may wait 0..N cycles
//  PC               out  32  address of the presented instruction (to IF/ID)
//  instruction      out  32  presented instruction, or NOP_INSTR (to IF/ID)
//  PC_next          out  32  PC+4 (to IF/ID)
//  fetch_valid      out  1   1 = instruction is a real fetched word
// BEHAVIOUR
//  - Registers: pc_q[31:0], ibuf[31:0], tgt_q[31:0], state in {IDLE, FETCH, HOLD, DRAIN}.
//  - Reset (rst=0, async): state=IDLE, pc_q=RESET_PC, ibuf=NOP_INSTR, tgt_q=0.
//    Outputs during reset: imem_req=0, fetch_valid=0, instruction=NOP_INSTR, PC=RESET_PC,
//    PC_next=RESET_PC+4.
//  - PC = pc_q and PC_next = pc_q+4 at all times. Addition wraps mod 2^32:
//    32'hFFFF_FFFC+4 = 0. imem_addr = pc_q, except in DRAIN, where it is the held in-flight address.
//  - IDLE: imem_req=0. The first clk edge after rst rises moves to FETCH.
//  - FETCH: imem_req=1.
//    . imem_ready=0: fetch_valid=0 and the state holds.
//    . imem_ready=1 and PC_WriteEN=1: instruction=imem_rdata and fetch_valid=1 in the same cycle
//      (zero-cycle pass-through); pc_q<=pc_q+4; stay in FETCH.
//    . imem_ready=1 and PC_WriteEN=0: fetch_valid=1, instruction=imem_rdata; ibuf<=imem_rdata;
//      go to HOLD.
//  - HOLD: imem_req=0, instruction=ibuf, fetch_valid=1. When PC_WriteEN=1, pc_q<=pc_q+4 and
//    go to FETCH. A stall of any length holds all outputs constant.
//  - Redirect has the highest priority and is evaluated every cycle outside IDLE/reset.
//    In its cycle fetch_valid=0 and instruction=NOP_INSTR, so the fetched word is squashed.
//    . In HOLD, or in FETCH with imem_ready=1: pc_q<={target[31:2],2'b00}; ibuf is discarded;
//      go to FETCH.
//    . In FETCH with imem_ready=0 (request in flight): tgt_q<=target; go to DRAIN.
//    . In DRAIN: tgt_q<=target (latest redirect wins).
//    . A redirect overrides a stall: PC_WriteEN is ignored in the redirect cycle.
//  - DRAIN: imem_req=1 with the original address until imem_ready=1; the returned data is
//    discarded; fetch_valid=0. On imem_ready=1: pc_q<=tgt_q (or the new target if redirect=1
//    that cycle); go to FETCH.
//  - The block never abandons an issued request; imem sees exactly one completion per request.
//  - Reset asserted mid-transaction returns to IDLE immediately; no request survives reset.
// TESTING
//  1 Reset release, imem always ready, PC_WriteEN=1 -> PC=0,4,8,C on successive cycles;
//    fetch_valid=1 from the 2nd cycle after release.
//  2 imem_ready delayed 3 cycles on addr 0x8 -> 3 cycles of fetch_valid=0 with NOP 0x00000013,
//    imem_addr held at 0x8, then the word at 0x8 is presented.
//  3 PC_WriteEN=0 for 4 cycles while the word at 0x10 returns -> state=HOLD; PC=0x10 and the
//    instruction held stable for all 4 cycles; imem_req=0; then PC advances to 0x14.
//  4 redirect to 0x100 while in HOLD at 0x20 -> next cycle PC=0x100 in FETCH; squash cycle
//    shows fetch_valid=0.
//  5 redirect to 0x200 while the fetch of 0x40 is pending (ready low 2 cycles) -> DRAIN keeps
//    imem_addr=0x40 until ready; the 0x40 data is dropped; the next request is 0x200.
//    A second redirect to 0x300 during DRAIN -> the next request is 0x300.
//  6 PC=0xFFFF_FFFC issues -> PC_next=0 and the following fetch is at 0; redirect_target=0x102
//    -> fetch at 0x100.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, fetches over a req/ready handshake, and feeds the IF/ID register.
// Handles hazard stalls, EX redirects, and NOP bubbles when no valid word is available.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_WriteEN,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] PC,
  output logic [31:0] instruction,
  output logic [31:0] PC_next,
  output logic        fetch_valid
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t            r_state, w_state_nxt;
  logic [XLEN-1:0]   r_pc, w_pc_nxt;
  logic [XLEN-1:0]   r_ibuf, w_ibuf_nxt;
  logic [XLEN-1:0]   r_tgt, w_tgt_nxt;
  logic [XLEN-1:0]   w_tgt_aligned;
  logic [XLEN-1:0]   w_pc_inc;

  assign w_tgt_aligned = redirect_target & ~XLEN'(3);
  assign w_pc_inc      = r_pc + XLEN'(4);

  assign PC        = r_pc;
  assign PC_next   = w_pc_inc;
  // r_pc is untouched while draining, so it is the held in-flight address
  assign imem_addr = r_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_ibuf  <= NOP_INSTR;
      r_tgt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ibuf  <= w_ibuf_nxt;
      r_tgt   <= w_tgt_nxt;
    end
  end

  // Next-state and handshake/output decode; redirect dominates stall in every state
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ibuf_nxt  = r_ibuf;
    w_tgt_nxt   = r_tgt;
    imem_req    = 1'b0;
    fetch_valid = 1'b0;
    instruction = NOP_INSTR;

    unique case (r_state)
      IDLE: begin
        w_state_nxt = FETCH;
      end

      FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          if (imem_ready) begin
            w_pc_nxt    = w_tgt_aligned;
            w_ibuf_nxt  = NOP_INSTR;
            w_state_nxt = FETCH;
          end else begin
            w_tgt_nxt   = w_tgt_aligned;
            w_state_nxt = DRAIN;
          end
        end else if (imem_ready) begin
          fetch_valid = 1'b1;
          instruction = imem_rdata;
          if (PC_WriteEN) begin
            w_pc_nxt = w_pc_inc;
          end else begin
            w_ibuf_nxt  = imem_rdata;
            w_state_nxt = HOLD;
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          w_pc_nxt    = w_tgt_aligned;
          w_ibuf_nxt  = NOP_INSTR;
          w_state_nxt = FETCH;
        end else begin
          fetch_valid = 1'b1;
          instruction = r_ibuf;
          if (PC_WriteEN) begin
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = FETCH;
          end
        end
      end

      DRAIN: begin
        imem_req = 1'b1;
        if (redirect) begin
          w_tgt_nxt = w_tgt_aligned;
        end
        if (imem_ready) begin
          w_pc_nxt    = redirect ? w_tgt_aligned : r_tgt;
          w_state_nxt = FETCH;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory returns addr^0xDEAD0000 when ready,
// 0x0BAD0BAD otherwise, so stale or held words are distinguishable.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        PC_WriteEN;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] PC;
  logic [31:0] instruction;
  logic [31:0] PC_next;
  logic        fetch_valid;

  int unsigned n_checks;
  int unsigned n_fails;

  localparam logic [31:0] NOP = 32'h0000_0013;

  instr_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .PC_WriteEN      (PC_WriteEN),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .imem_ready      (imem_ready),
    .PC              (PC),
    .instruction     (instruction),
    .PC_next         (PC_next),
    .fetch_valid     (fetch_valid)
  );

  assign imem_rdata = imem_ready ? (imem_addr ^ 32'hDEAD_0000) : 32'h0BAD_0BAD;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge; inputs are then driven
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic rdy, input logic redir, input logic [31:0] tgt);
    PC_WriteEN      = we;
    imem_ready      = rdy;
    redirect        = redir;
    redirect_target = tgt;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                            input logic vld, input logic [31:0] ins, input logic [31:0] pc);
    check_eq({tag, ".req"},   32'(imem_req),    32'(req));
    check_eq({tag, ".addr"},  imem_addr,        addr);
    check_eq({tag, ".valid"}, 32'(fetch_valid), 32'(vld));
    check_eq({tag, ".instr"}, instruction,      ins);
    check_eq({tag, ".pc"},    PC,               pc);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h0);

    // Reset state
    next_cycle();
    #1;
    check_eq("rst.req",     32'(imem_req),    32'h0);
    check_eq("rst.valid",   32'(fetch_valid), 32'h0);
    check_eq("rst.instr",   instruction,      NOP);
    check_eq("rst.pc",      PC,               32'h0);
    check_eq("rst.pc_next", PC_next,          32'h4);

    // 1: release reset, sequential fetch
    next_cycle(); rst = 1'b1; drive(1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("t1.idle.req",   32'(imem_req),    32'h0);
    check_eq("t1.idle.valid", 32'(fetch_valid), 32'h0);
    next_cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0);
    expect_out("t1.pc0", 1'b1, 32'h0, 1'b1, 32'hDEAD_0000, 32'h0);
    next_cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0);
    expect_out("t1.pc4", 1'b1, 32'h4, 1'b1, 32'hDEAD_0004, 32'h4);

    // 2: three wait cycles on 0x8
    for (int i = 0; i < 3; i++) begin
      next_cycle(); drive(1'b1, 1'b0, 1'b0, 32'h0);
      expect_out("t2.wait", 1'b1, 32'h8, 1'b0, NOP, 32'h8);
    end
    next_cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0);
    expect_out("t2.done", 1'b1, 32'h8, 1'b1, 32'hDEAD_0008, 32'h8);
    next_cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0);
    expect_out("t2.pcC", 1'b1, 32'hC, 1'b1, 32'hDEAD_000C, 32'hC);

    // 3: stall four cycles while 0x10 returns, then advance
    next_cycle(); drive(1'b0, 1'b1, 1'b0, 32'h0);
    expect_out("t3.fetch", 1'b1, 32'h10, 1'b1, 32'hDEAD_0010, 32'h10);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); drive(1'b0, 1'b0, 1'b0, 32'h0);
      expect_out("t3.hold", 1'b0, 32'h10, 1'b1, 32'hDEAD_0010, 32'h10);
      check_eq("t3.hold.pc_next", PC_next, 32'h14);
    end
    next_cycle(); drive(1'b1, 1'b0, 1'b0, 32'h0);
    expect_out("t3.release", 1'b0, 32'h10, 1'b1, 32'hDEAD_0010, 32'h10);
    next_cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0);
    expect_out("t3.pc14", 1'b1, 32'h14, 1'b1, 32'hDEAD_0014, 32'h14);
    next_cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0);
    next_cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("t3.pc1C", PC, 32'h1C);

    // 4: redirect from HOLD at 0x20
    next_cycle(); drive(1'b0, 1'b1, 1'b0, 32'h0);
    expect_out("t4.fetch20", 1'b1, 32'h20, 1'b1, 32'hDEAD_0020, 32'h20);
    next_cycle(); drive(1'b0, 1'b0, 1'b1, 32'h100);
    expect_out("t4.squash", 1'b0, 32'h20, 1'b0, NOP, 32'h20);
    next_cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0);
    expect_out("t4.pc100", 1'b1, 32'h100, 1'b1, 32'hDEAD_0100, 32'h100);

    // 5: redirect while 0x40 is in flight, then a second redirect inside DRAIN
    next_cycle(); drive(1'b1, 1'b1, 1'b1, 32'h40);
    expect_out("t5.redir40", 1'b1, 32'h104, 1'b0, NOP, 32'h104);
    next_cycle(); drive(1'b1, 1'b0, 1'b1, 32'h200);
    expect_out("t5.pend40", 1'b1, 32'h40, 1'b0, NOP, 32'h40);
    next_cycle(); drive(1'b1, 1'b0, 1'b0, 32'h0);
    expect_out("t5.drain", 1'b1, 32'h40, 1'b0, NOP, 32'h40);
    next_cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0);
    expect_out("t5.drop40", 1'b1, 32'h40, 1'b0, NOP, 32'h40);
    next_cycle(); drive(1'b1, 1'b0, 1'b1, 32'h280);
    expect_out("t5.pc200", 1'b1, 32'h200, 1'b0, NOP, 32'h200);
    next_cycle(); drive(1'b0, 1'b0, 1'b1, 32'h300);
    expect_out("t5.drain2", 1'b1, 32'h200, 1'b0, NOP, 32'h200);
    next_cycle(); drive(1'b0, 1'b1, 1'b0, 32'h0);
    expect_out("t5.drop200", 1'b1, 32'h200, 1'b0, NOP, 32'h200);
    next_cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0);
    expect_out("t5.pc300", 1'b1, 32'h300, 1'b1, 32'hDEAD_0300, 32'h300);

    // 6: wrap at the top of the address space and target alignment
    next_cycle(); drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    check_eq("t6.squash.valid", 32'(fetch_valid), 32'h0);
    next_cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0);
    expect_out("t6.top", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h2152_FFFC, 32'hFFFF_FFFC);
    check_eq("t6.top.pc_next", PC_next, 32'h0);
    next_cycle(); drive(1'b1, 1'b1, 1'b1, 32'h102);
    expect_out("t6.wrap0", 1'b1, 32'h0, 1'b0, NOP, 32'h0);
    next_cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0);
    expect_out("t6.align", 1'b1, 32'h100, 1'b1, 32'hDEAD_0100, 32'h100);

    // Reset in the middle of a pending request
    next_cycle(); drive(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("rst2.pre.req", 32'(imem_req), 32'h1);
    rst = 1'b0;
    #1;
    expect_out("rst2.async", 1'b0, 32'h0, 1'b0, NOP, 32'h0);
    next_cycle(); rst = 1'b1; drive(1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("rst2.idle.req", 32'(imem_req), 32'h0);
    next_cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0);
    expect_out("rst2.pc0", 1'b1, 32'h0, 1'b1, 32'hDEAD_0000, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
